// File: rtl/gmem_arb_pkg.sv
// Shared definitions for the graph-memory port arbiter.
// Contents:
//   arb_state_e     - arbiter control FSM states (run, drain, done)
//   Def*            - default parameter values used by the interface and modules
//   tag_width()     - width of a requester index, minimum 1 bit
//   cnt_width()     - width of an occupancy counter able to hold 0..depth
package gmem_arb_pkg;

  localparam int unsigned DefNumReq         = 2;
  localparam int unsigned DefMaxOutstanding = 4;
  localparam int unsigned DefAddrWidth      = 32;
  localparam int unsigned DefDataWidth      = 32;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StDone  = 2'd2
  } arb_state_e;

  function automatic int unsigned tag_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/gmem_port_arbiter_if.sv
// Bundle of requester, memory and control signals around the arbiter.
// Signal names follow the arbiter's point of view (_in driven towards it, _out driven by it).
//   req_valid_in / req_addr_in / req_lock_in : per-requester read requests
//   req_grant_out                            : one-hot combinational grant
//   resp_valid_out / resp_data_out           : one-hot return strobe and shared data
//   mem_addr_out / mem_valid_out             : registered memory read command
//   mem_data_in / mem_valid_in               : in-order memory read data
//   flush_in / flush_done_out / error_out    : drain control and sticky error
// Modports: slave = arbiter, master = requesters plus memory.
interface gmem_port_arbiter_if import gmem_arb_pkg::*; #(
  parameter int unsigned NUM_REQ    = DefNumReq,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth
) ();

  logic [NUM_REQ-1:0]                 req_valid_in;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr_in;
  logic [NUM_REQ-1:0]                 req_lock_in;
  logic [NUM_REQ-1:0]                 req_grant_out;
  logic [NUM_REQ-1:0]                 resp_valid_out;
  logic [DATA_WIDTH-1:0]              resp_data_out;
  logic [ADDR_WIDTH-1:0]              mem_addr_out;
  logic                               mem_valid_out;
  logic [DATA_WIDTH-1:0]              mem_data_in;
  logic                               mem_valid_in;
  logic                               flush_in;
  logic                               flush_done_out;
  logic                               error_out;

  modport slave (
    input  req_valid_in, req_addr_in, req_lock_in, mem_data_in, mem_valid_in, flush_in,
    output req_grant_out, resp_valid_out, resp_data_out, mem_addr_out, mem_valid_out,
           flush_done_out, error_out
  );

  modport master (
    output req_valid_in, req_addr_in, req_lock_in, mem_data_in, mem_valid_in, flush_in,
    input  req_grant_out, resp_valid_out, resp_data_out, mem_addr_out, mem_valid_out,
           flush_done_out, error_out
  );

endinterface

// File: rtl/gmem_arb_tag_fifo.sv
// Synchronous FIFO of requester indices recording who owns each in-flight read.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset (empties the FIFO)
//   push_i/data_i : enqueue an owner tag (ignored when full)
//   pop_i         : dequeue the head tag (ignored when empty)
//   head_o        : current head tag
//   full_o/empty_o/count_o : occupancy status
module gmem_arb_tag_fifo import gmem_arb_pkg::*; #(
  parameter int unsigned DEPTH = DefMaxOutstanding,
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read as valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/gmem_port_arbiter.sv
// Round-robin arbiter sharing one in-order graph-memory read port among NUM_REQ requesters.
// Grants are combinational; the memory command and the response are registered. A tag FIFO
// records the owner of each in-flight read so returning data is steered back in order.
// flush_in stops granting until all reads have returned, then flush_done_out pulses once.
// Optional feature: define GMEM_ARB_LOCK_EN to let the last-granted requester keep priority
// while it holds req_lock_in and req_valid_in; otherwise req_lock_in is ignored.
// Ports:
//   clk_in  : clock
//   rst_in  : synchronous active-high reset
//   arb_io  : gmem_port_arbiter_if.slave (requests, grants, responses, memory, flush, error)
module gmem_port_arbiter import gmem_arb_pkg::*; #(
  parameter int unsigned NUM_REQ         = DefNumReq,
  parameter int unsigned MAX_OUTSTANDING = DefMaxOutstanding,
  parameter int unsigned ADDR_WIDTH      = DefAddrWidth,
  parameter int unsigned DATA_WIDTH      = DefDataWidth
) (
  input logic                 clk_in,
  input logic                 rst_in,
  gmem_port_arbiter_if.slave  arb_io
);

  localparam int unsigned TagW = tag_width(NUM_REQ);
  localparam int unsigned CntW = cnt_width(MAX_OUTSTANDING);

  typedef logic [TagW-1:0] tag_t;

  arb_state_e            state_q;
  tag_t                  ptr_q;
  logic                  mem_valid_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_data_q;
  logic                  flush_done_q;
  logic                  error_q;

  logic                  grant_ok;
  logic                  grant_any;
  tag_t                  grant_idx;
  logic [NUM_REQ-1:0]    grant_vec;
  logic                  mem_pop;
  logic                  mem_spurious;
  tag_t                  fifo_head;
  logic                  fifo_full, fifo_empty;
  logic [CntW-1:0]       out_count;

  gmem_arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (TagW),
    .CNT_W (CntW)
  ) u_tag_fifo (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .push_i  (grant_any),
    .data_i  (grant_idx),
    .pop_i   (mem_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (out_count)
  );

  // Full FIFO blocks grants even if a pop lands in the same cycle.
  assign grant_ok     = (state_q == StRun) && !fifo_full && !rst_in;
  assign mem_pop      = arb_io.mem_valid_in && !fifo_empty;
  assign mem_spurious = arb_io.mem_valid_in && fifo_empty;

  function automatic tag_t rr_idx(input tag_t base, input int unsigned off);
    int unsigned sum;
    sum = (32'(base) + off) % NUM_REQ;
    return tag_t'(sum);
  endfunction

`ifdef GMEM_ARB_LOCK_EN
  // ptr_q only names a real owner once something has been granted since reset.
  logic owner_valid_q;

  always_ff @(posedge clk_in) begin
    if (rst_in)         owner_valid_q <= 1'b0;
    else if (grant_any) owner_valid_q <= 1'b1;
  end
`else
  logic [NUM_REQ-1:0] unused_lock;
  assign unused_lock = arb_io.req_lock_in;
`endif

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    if (grant_ok) begin
`ifdef GMEM_ARB_LOCK_EN
      if (owner_valid_q && arb_io.req_valid_in[ptr_q] && arb_io.req_lock_in[ptr_q]) begin
        grant_any = 1'b1;
        grant_idx = ptr_q;
      end
`endif
      // Search starts one past the last grant and wraps back to it.
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
        if (!grant_any && arb_io.req_valid_in[rr_idx(ptr_q, off)]) begin
          grant_any = 1'b1;
          grant_idx = rr_idx(ptr_q, off);
        end
      end
    end
  end

  always_comb begin
    grant_vec            = '0;
    grant_vec[grant_idx] = grant_any;
  end

  always_comb begin
    resp_valid_d            = '0;
    resp_valid_d[fifo_head] = mem_pop;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= StRun;
      ptr_q        <= tag_t'(NUM_REQ - 1);
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      flush_done_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      mem_valid_q  <= grant_any;
      resp_valid_q <= resp_valid_d;
      flush_done_q <= 1'b0;
      if (grant_any) begin
        mem_addr_q <= arb_io.req_addr_in[grant_idx];
        ptr_q      <= grant_idx;
      end
      if (mem_pop)      resp_data_q <= arb_io.mem_data_in;
      if (mem_spurious) error_q     <= 1'b1;

      unique case (state_q)
        StRun: begin
          if (arb_io.flush_in) state_q <= StDrain;
        end
        StDrain: begin
          // Count already reflects the last pop; its response is on the outputs this cycle.
          if (out_count == '0) begin
            state_q      <= StDone;
            flush_done_q <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StRun;
        end
        default: begin
          state_q <= StRun;
        end
      endcase
    end
  end

  assign arb_io.req_grant_out  = grant_vec;
  assign arb_io.resp_valid_out = resp_valid_q;
  assign arb_io.resp_data_out  = resp_data_q;
  assign arb_io.mem_addr_out   = mem_addr_q;
  assign arb_io.mem_valid_out  = mem_valid_q;
  assign arb_io.flush_done_out = flush_done_q;
  assign arb_io.error_out      = error_q;

endmodule

// File: tb/tb_gmem_port_arbiter.sv
// Randomized and directed bench for gmem_port_arbiter with a queue-based reference model.
// The model tracks in-flight owners as a queue, the last granted requester and a
// run/drain/done phase; expected memory commands and responses go into scoreboard queues
// that a separate monitor pops whenever the DUT presents them.
module tb_gmem_port_arbiter;

  localparam int unsigned NReq   = 2;
  localparam int unsigned MaxOut = 4;
  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 32;

  typedef struct {
    int unsigned   due;
    logic [DW-1:0] data;
  } mem_beat_t;

  typedef struct {
    int            owner;
    logic [DW-1:0] data;
  } resp_t;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  gmem_port_arbiter_if #(.NUM_REQ(NReq), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) arb_if ();

  gmem_port_arbiter #(
    .NUM_REQ         (NReq),
    .MAX_OUTSTANDING (MaxOut),
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .arb_io (arb_if)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus for the next cycle.
  logic                       v_rst;
  logic [NReq-1:0]            v_valid;
  logic [NReq-1:0][AW-1:0]    v_addr;
  logic [NReq-1:0]            v_lock;
  logic                       v_flush;
  logic                       v_spur;
  logic                       mem_stall;
  int unsigned                fix_lat;
  logic                       fix_data_en;
  logic [DW-1:0]              fix_data;

  // Reference model and scoreboard.
  int            m_last;
  int            m_phase;
  bit            m_err;
  int            owners[$];
  mem_beat_t     pend[$];
  logic [AW-1:0] exp_addr[$];
  resp_t         exp_resp[$];
  int unsigned   cyc = 0;
  int unsigned   last_due = 0;
  bit            mon_on = 1'b0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int pick();
    int base;
    base = (m_last < 0) ? NReq - 1 : m_last;
`ifdef GMEM_ARB_LOCK_EN
    if (m_last >= 0 && v_valid[m_last] && v_lock[m_last]) return m_last;
`endif
    for (int k = 1; k <= NReq; k++) begin
      int c;
      c = (base + k) % NReq;
      if (v_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic step();
    logic            mv;
    logic [DW-1:0]   md;
    logic [NReq-1:0] eg;
    int              n0;
    int              g;
    resp_t           r;
    mem_beat_t       b;
    @(posedge clk_in);
    #1;
    rst_in              = v_rst;
    arb_if.req_valid_in = v_valid;
    arb_if.req_addr_in  = v_addr;
    arb_if.req_lock_in  = v_lock;
    arb_if.flush_in     = v_flush;
    mv = 1'b0;
    md = '0;
    if (!v_rst) begin
      if (v_spur) begin
        mv = 1'b1;
        md = $urandom;
      end else if (!mem_stall && pend.size() > 0 && pend[0].due <= cyc) begin
        mv = 1'b1;
        md = pend[0].data;
        void'(pend.pop_front());
      end
    end
    arb_if.mem_valid_in = mv;
    arb_if.mem_data_in  = md;
    @(negedge clk_in);
    #2;
    if (mon_on) begin
      check("flush_done_out", {63'd0, arb_if.flush_done_out}, {63'd0, (m_phase == 2)});
      check("error_out", {63'd0, arb_if.error_out}, {63'd0, m_err});
    end
    eg = '0;
    if (v_rst) begin
      m_phase = 0;
      m_last  = -1;
      m_err   = 1'b0;
      owners.delete();
    end else begin
      n0 = owners.size();
      if (mv) begin
        if (n0 == 0) m_err = 1'b1;
        else begin
          r.owner = owners.pop_front();
          r.data  = md;
          exp_resp.push_back(r);
        end
      end
      g = -1;
      if (m_phase == 0 && n0 < MaxOut) g = pick();
      if (g >= 0) begin
        eg[g] = 1'b1;
        owners.push_back(g);
        exp_addr.push_back(v_addr[g]);
        m_last = g;
      end
      case (m_phase)
        0:       if (v_flush) m_phase = 1;
        1:       if (n0 == 0) m_phase = 2;
        default: m_phase = 0;
      endcase
    end
    if (mon_on) check("req_grant_out", 64'(arb_if.req_grant_out), 64'(eg));
    // Behavioural memory: accept each command and schedule an in-order return.
    if (arb_if.mem_valid_out === 1'b1) begin
      b.due  = cyc + ((fix_lat != 0) ? fix_lat : $urandom_range(1, 4));
      if (b.due <= last_due) b.due = last_due + 1;
      last_due = b.due;
      b.data = fix_data_en ? fix_data : $urandom;
      pend.push_back(b);
    end
    cyc++;
  endtask

  task automatic drain_all();
    int n;
    n = 0;
    v_valid   = '0;
    v_flush   = 1'b0;
    v_spur    = 1'b0;
    v_rst     = 1'b0;
    mem_stall = 1'b0;
    while ((owners.size() != 0 || pend.size() != 0 || m_phase != 0) && n < 200) begin
      step();
      n++;
    end
    step();
    step();
    check("drain_complete", {63'd0, (owners.size() == 0 && pend.size() == 0)}, 64'd1);
  endtask

  // Monitor: every expected command/response must show up exactly one cycle after it is queued.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk_in);
      if (mon_on) begin
        check("mem_valid_out", {63'd0, arb_if.mem_valid_out}, {63'd0, (exp_addr.size() != 0)});
        if (exp_addr.size() != 0) begin
          if (arb_if.mem_valid_out === 1'b1)
            check("mem_addr_out", 64'(arb_if.mem_addr_out), 64'(exp_addr[0]));
          void'(exp_addr.pop_front());
        end
        check("resp_present", {63'd0, (arb_if.resp_valid_out != '0)},
              {63'd0, (exp_resp.size() != 0)});
        if (exp_resp.size() != 0) begin
          r = exp_resp.pop_front();
          if (arb_if.resp_valid_out != '0) begin
            check("resp_valid_out", 64'(arb_if.resp_valid_out), 64'd1 << r.owner);
            check("resp_data_out", 64'(arb_if.resp_data_out), 64'(r.data));
          end
        end
      end
    end
  end

  initial begin
    v_rst = 1'b1; v_valid = '0; v_addr = '0; v_lock = '0; v_flush = 1'b0; v_spur = 1'b0;
    mem_stall = 1'b0; fix_lat = 0; fix_data_en = 1'b0; fix_data = '0;
    m_last = -1; m_phase = 0; m_err = 1'b0;
    rst_in = 1'b1;
    arb_if.req_valid_in = '0; arb_if.req_addr_in = '0; arb_if.req_lock_in = '0;
    arb_if.flush_in = 1'b0; arb_if.mem_valid_in = 1'b0; arb_if.mem_data_in = '0;

    step();
    mon_on = 1'b1;
    step();
    check("reset_mem_addr_out", 64'(arb_if.mem_addr_out), 64'd0);
    check("reset_resp_data_out", 64'(arb_if.resp_data_out), 64'd0);
    check("reset_resp_valid_out", 64'(arb_if.resp_valid_out), 64'd0);
    v_rst = 1'b0;

    // Both requesters continuously: requester 0 first after reset, then alternation.
    v_addr[0] = 32'h100; v_addr[1] = 32'h200; v_valid = 2'b11; fix_lat = 1;
    repeat (6) step();
    drain_all();

    // Single requester, latency 2, known data.
    v_addr[0] = 32'h10; v_valid = 2'b01; fix_lat = 2; fix_data_en = 1'b1; fix_data = 32'hAB;
    step();
    v_valid = '0;
    repeat (5) step();
    fix_data_en = 1'b0;

    // Stalled memory: outstanding limit caps grants until the first return.
    fix_lat = 1; mem_stall = 1'b1; v_valid = 2'b11;
    repeat (8) step();
    mem_stall = 1'b0;
    repeat (8) step();
    drain_all();

    // Flush with a grant in the same cycle, three reads outstanding.
    mem_stall = 1'b1; v_valid = 2'b11;
    repeat (2) step();
    v_flush = 1'b1;
    step();
    v_flush = 1'b0; mem_stall = 1'b0;
    repeat (15) step();
    drain_all();

    // Requester 1 asserting lock while requester 0 competes.
    v_valid = 2'b11; v_lock = 2'b10;
    repeat (5) step();
    v_lock = '0;
    repeat (4) step();
    drain_all();

    // Spurious return with nothing outstanding: sticky error until reset.
    v_spur = 1'b1;
    step();
    v_spur = 1'b0;
    repeat (3) step();
    check("error_sticky", {63'd0, arb_if.error_out}, 64'd1);
    v_rst = 1'b1;
    step();
    v_rst = 1'b0;
    repeat (2) step();

    // Randomized traffic including flushes, stalls, lock and occasional reset.
    fix_lat = 0;
    repeat (600) begin
      v_valid   = NReq'($urandom);
      v_addr[0] = $urandom;
      v_addr[1] = $urandom;
      v_lock    = NReq'($urandom);
      v_flush   = ($urandom_range(0, 15) == 0);
      mem_stall = ($urandom_range(0, 3) == 0);
      v_rst     = ($urandom_range(0, 149) == 0);
      v_spur    = ($urandom_range(0, 299) == 0);
      step();
    end
    drain_all();

    check("exp_addr_empty", 64'(exp_addr.size()), 64'd0);
    check("exp_resp_empty", 64'(exp_resp.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
